// File: rtl/pipe_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : haz_pkg
//  Purpose  : Shared types and constants for the pipeline hazard unit
//             (FSM state encoding, forwarding-source encoding, bubble limits).
//  Revision : 1.0  initial release
// ============================================================================
package haz_pkg;

    // Hazard FSM state; value is exported on haz_state
    typedef enum logic [1:0] {
        HAZ_RUN = 2'd0,
        HAZ_LU  = 2'd1,
        HAZ_MW  = 2'd2
    } haz_state_e;

    // Operand source chosen by a forwarding mux
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_src_e;

    // Largest supported load-use bubble depth and the counter width to hold it
    localparam int C_LOAD_BUBBLES_MAX = 7;
    localparam int C_HAZ_CNT_W        = 3;

endpackage : haz_pkg
`default_nettype wire

// File: rtl/pipe_hazard_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_unit_if
//  Purpose  : Bundle of pipeline-side signals consumed and driven by the
//             hazard unit. master = pipeline side, slave = hazard unit.
//             Optional macro HAZ_PERF_CNT_EN adds the performance counters.
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_hazard_unit_if #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
);
    // ID stage
    logic [NUM_RD-1:0]    id_rd_en;
    logic [NUM_RD*AW-1:0] id_rd_addr;
    logic [NUM_RD*DW-1:0] id_rf_data;
    logic                 id_branch_taken;
    // EX stage
    logic                 ex_regwrite;
    logic                 ex_isload;
    logic [AW-1:0]        ex_waddr;
    logic [DW-1:0]        ex_result;
    // MEM stage
    logic                 mem_regwrite;
    logic                 mem_memtoreg;
    logic [AW-1:0]        mem_waddr;
    logic [DW-1:0]        mem_aluresult;
    logic [DW-1:0]        mem_rdata;
    logic                 mem_rdata_vld;
    // WB stage
    logic                 wb_regwrite;
    logic [AW-1:0]        wb_waddr;
    logic [DW-1:0]        wb_wdata;
    // Hazard unit results
    logic [NUM_RD*DW-1:0] id_fwd_data;
    logic                 hold_front;
    logic                 bubble_ex;
    logic                 hold_back;
    logic                 flush_ifid;
    logic                 branch_ok;
    logic [1:0]           haz_state;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]          perf_lu_cycles;
    logic [31:0]          perf_mw_cycles;
    logic [31:0]          perf_flushes;

    modport master (
        output id_rd_en, id_rd_addr, id_rf_data, id_branch_taken,
        output ex_regwrite, ex_isload, ex_waddr, ex_result,
        output mem_regwrite, mem_memtoreg, mem_waddr, mem_aluresult, mem_rdata, mem_rdata_vld,
        output wb_regwrite, wb_waddr, wb_wdata,
        input  id_fwd_data, hold_front, bubble_ex, hold_back, flush_ifid, branch_ok, haz_state,
        input  perf_lu_cycles, perf_mw_cycles, perf_flushes
    );
    modport slave (
        input  id_rd_en, id_rd_addr, id_rf_data, id_branch_taken,
        input  ex_regwrite, ex_isload, ex_waddr, ex_result,
        input  mem_regwrite, mem_memtoreg, mem_waddr, mem_aluresult, mem_rdata, mem_rdata_vld,
        input  wb_regwrite, wb_waddr, wb_wdata,
        output id_fwd_data, hold_front, bubble_ex, hold_back, flush_ifid, branch_ok, haz_state,
        output perf_lu_cycles, perf_mw_cycles, perf_flushes
    );
`else
    modport master (
        output id_rd_en, id_rd_addr, id_rf_data, id_branch_taken,
        output ex_regwrite, ex_isload, ex_waddr, ex_result,
        output mem_regwrite, mem_memtoreg, mem_waddr, mem_aluresult, mem_rdata, mem_rdata_vld,
        output wb_regwrite, wb_waddr, wb_wdata,
        input  id_fwd_data, hold_front, bubble_ex, hold_back, flush_ifid, branch_ok, haz_state
    );
    modport slave (
        input  id_rd_en, id_rd_addr, id_rf_data, id_branch_taken,
        input  ex_regwrite, ex_isload, ex_waddr, ex_result,
        input  mem_regwrite, mem_memtoreg, mem_waddr, mem_aluresult, mem_rdata, mem_rdata_vld,
        input  wb_regwrite, wb_waddr, wb_wdata,
        output id_fwd_data, hold_front, bubble_ex, hold_back, flush_ifid, branch_ok, haz_state
    );
`endif
endinterface : pipe_hazard_unit_if
`default_nettype wire

// File: rtl/pipe_hazard_unit_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module   : haz_fwd_mux
//  Purpose  : Single read-port priority forwarding mux (EX > MEM > WB > RF).
//  Revision : 1.0  initial release
// ============================================================================
module haz_fwd_mux
    import haz_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  wire logic          i_rd_en,
    input  wire logic [AW-1:0] i_rd_addr,
    input  wire logic [DW-1:0] i_rf_data,
    input  wire logic          i_ex_regwrite,
    input  wire logic          i_ex_isload,
    input  wire logic [AW-1:0] i_ex_waddr,
    input  wire logic [DW-1:0] i_ex_result,
    input  wire logic          i_mem_regwrite,
    input  wire logic          i_mem_memtoreg,
    input  wire logic [AW-1:0] i_mem_waddr,
    input  wire logic [DW-1:0] i_mem_aluresult,
    input  wire logic [DW-1:0] i_mem_rdata,
    input  wire logic          i_wb_regwrite,
    input  wire logic [AW-1:0] i_wb_waddr,
    input  wire logic [DW-1:0] i_wb_wdata,
    output logic      [DW-1:0] o_data
);

    fwd_src_e w_src;

    // Pick the youngest producer of the operand; r0 and idle ports never forward.
    // A load in EX has no data yet, so it is skipped here and covered by the interlock.
    always_comb begin
        w_src = FWD_RF;
        if (i_rd_en && (i_rd_addr != '0)) begin
            if (i_ex_regwrite && !i_ex_isload && (i_ex_waddr == i_rd_addr))
                w_src = FWD_EX;
            else if (i_mem_regwrite && (i_mem_waddr == i_rd_addr))
                w_src = FWD_MEM;
            else if (i_wb_regwrite && (i_wb_waddr == i_rd_addr))
                w_src = FWD_WB;
        end
    end

    // Steer the selected source onto the operand bus
    always_comb begin
        o_data = i_rf_data;
        case (w_src)
            FWD_EX:  o_data = i_ex_result;
            FWD_MEM: o_data = i_mem_memtoreg ? i_mem_rdata : i_mem_aluresult;
            FWD_WB:  o_data = i_wb_wdata;
            default: o_data = i_rf_data;
        endcase
    end

endmodule : haz_fwd_mux
`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_unit
//  Purpose  : Operand forwarding, load-use interlock, data-memory wait freeze
//             and branch flush control for the in-order pipeline.
//             Optional macro HAZ_PERF_CNT_EN adds saturating perf counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_unit
    import haz_pkg::*;
#(
    parameter int DW           = 32,
    parameter int AW           = 5,
    parameter int NUM_RD       = 2,
    parameter int LOAD_BUBBLES = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pipe_hazard_unit_if.slave bus
);

    // Bubbles still owed after the first one, which is issued from RUN
    localparam logic [C_HAZ_CNT_W-1:0] C_CNT_INIT = C_HAZ_CNT_W'(LOAD_BUBBLES - 1);
    localparam logic [C_HAZ_CNT_W-1:0] C_CNT_ONE  = C_HAZ_CNT_W'(1);

    haz_state_e             r_state;
    logic [C_HAZ_CNT_W-1:0] r_cnt;

    logic [NUM_RD*DW-1:0]   w_fwd;
    logic                   w_port_hit;
    logic                   w_lu;
    logic                   w_mw;
    logic                   w_hold_front;
    logic                   w_bubble_ex;
    logic                   w_hold_back;
    logic                   w_branch_ok;

    // One priority forwarding mux per ID read port
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_fwd
        haz_fwd_mux #(
            .DW (DW),
            .AW (AW)
        ) u_fwd_mux (
            .i_rd_en         (bus.id_rd_en[gi]),
            .i_rd_addr       (bus.id_rd_addr[gi*AW +: AW]),
            .i_rf_data       (bus.id_rf_data[gi*DW +: DW]),
            .i_ex_regwrite   (bus.ex_regwrite),
            .i_ex_isload     (bus.ex_isload),
            .i_ex_waddr      (bus.ex_waddr),
            .i_ex_result     (bus.ex_result),
            .i_mem_regwrite  (bus.mem_regwrite),
            .i_mem_memtoreg  (bus.mem_memtoreg),
            .i_mem_waddr     (bus.mem_waddr),
            .i_mem_aluresult (bus.mem_aluresult),
            .i_mem_rdata     (bus.mem_rdata),
            .i_wb_regwrite   (bus.wb_regwrite),
            .i_wb_waddr      (bus.wb_waddr),
            .i_wb_wdata      (bus.wb_wdata),
            .o_data          (w_fwd[gi*DW +: DW])
        );
    end

    // Does any enabled ID read port consume the register the EX load writes?
    always_comb begin
        w_port_hit = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (bus.id_rd_en[i] && (bus.id_rd_addr[i*AW +: AW] == bus.ex_waddr))
                w_port_hit = 1'b1;
        end
    end

    assign w_lu = bus.ex_regwrite & bus.ex_isload & (bus.ex_waddr != '0) & w_port_hit;
    assign w_mw = bus.mem_memtoreg & bus.mem_regwrite & ~bus.mem_rdata_vld;

    // Hazard FSM: a memory wait pre-empts load-use bubbling, which resumes afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HAZ_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                HAZ_RUN: begin
                    if (w_mw) begin
                        r_state <= HAZ_MW;
                    end else if (w_lu && (LOAD_BUBBLES > 1)) begin
                        r_state <= HAZ_LU;
                        r_cnt   <= C_CNT_INIT;
                    end
                end
                HAZ_LU: begin
                    if (w_mw) begin
                        r_state <= HAZ_MW;
                    end else begin
                        r_cnt <= r_cnt - C_CNT_ONE;
                        if (r_cnt == C_CNT_ONE)
                            r_state <= HAZ_RUN;
                    end
                end
                HAZ_MW: begin
                    if (bus.mem_rdata_vld)
                        r_state <= (r_cnt != '0) ? HAZ_LU : HAZ_RUN;
                end
                default: begin
                    r_state <= HAZ_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Stall controls decoded from state and the live hazard conditions; quiet in reset
    always_comb begin
        w_hold_front = 1'b0;
        w_bubble_ex  = 1'b0;
        w_hold_back  = 1'b0;
        if (!rst) begin
            case (r_state)
                HAZ_RUN: begin
                    if (w_mw) begin
                        w_hold_front = 1'b1;
                        w_hold_back  = 1'b1;
                    end else if (w_lu) begin
                        w_hold_front = 1'b1;
                        w_bubble_ex  = 1'b1;
                    end
                end
                HAZ_LU: begin
                    if (w_mw) begin
                        w_hold_front = 1'b1;
                        w_hold_back  = 1'b1;
                    end else begin
                        w_hold_front = 1'b1;
                        w_bubble_ex  = 1'b1;
                    end
                end
                HAZ_MW: begin
                    w_hold_front = ~bus.mem_rdata_vld;
                    w_hold_back  = ~bus.mem_rdata_vld;
                end
                default: begin
                    w_hold_front = 1'b0;
                end
            endcase
        end
    end

    // A taken branch only redirects once its operands are current (front not held)
    assign w_branch_ok = bus.id_branch_taken & ~w_hold_front & ~rst;

    assign bus.id_fwd_data = w_fwd;
    assign bus.hold_front  = w_hold_front;
    assign bus.bubble_ex   = w_bubble_ex;
    assign bus.hold_back   = w_hold_back;
    assign bus.branch_ok   = w_branch_ok;
    assign bus.flush_ifid  = w_branch_ok;
    assign bus.haz_state   = r_state;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_perf_lu;
    logic [31:0] r_perf_mw;
    logic [31:0] r_perf_fl;

    // Saturating event counters for bubbles, memory-wait cycles and flushes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_lu <= '0;
            r_perf_mw <= '0;
            r_perf_fl <= '0;
        end else begin
            if (w_bubble_ex && (r_perf_lu != 32'hFFFF_FFFF))
                r_perf_lu <= r_perf_lu + 32'd1;
            if ((r_state == HAZ_MW) && (r_perf_mw != 32'hFFFF_FFFF))
                r_perf_mw <= r_perf_mw + 32'd1;
            if (w_branch_ok && (r_perf_fl != 32'hFFFF_FFFF))
                r_perf_fl <= r_perf_fl + 32'd1;
        end
    end

    assign bus.perf_lu_cycles = r_perf_lu;
    assign bus.perf_mw_cycles = r_perf_mw;
    assign bus.perf_flushes   = r_perf_fl;
`endif

endmodule : pipe_hazard_unit
`default_nettype wire

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised successor to the pipeline's separate forwarding and stall logic: one block owns operand forwarding, load-use interlock, memory-wait freeze and branch flush.
- Sits beside the ID stage. Feeds forwarded operands to branch compare and ID/EX, and drives the hold/bubble/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Generalised in read-port count, load-use bubble depth, and variable-latency data memory via a valid handshake.

Parameters:
- DW, 32, data width.
- AW, 5, register-address width.
- NUM_RD, 2, number of ID read ports.
- LOAD_BUBBLES, 1, bubble cycles inserted per load-use hazard (1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- id_rd_en  in  NUM_RD  read-port enable.
- id_rd_addr  in  NUM_RD*AW  read addresses; port i at [i*AW +: AW].
- id_rf_data  in  NUM_RD*DW  register-file read data.
- id_branch_taken  in  1  ID branch/jump resolved taken.
- ex_regwrite  in  1  EX-stage write enable.
- ex_isload  in  1  EX instruction is a load.
- ex_waddr  in  AW  EX-stage destination.
- ex_result  in  DW  EX ALU result.
- mem_regwrite  in  1  MEM-stage write enable.
- mem_memtoreg  in  1  MEM instruction is a load.
- mem_waddr  in  AW  MEM-stage destination.
- mem_aluresult  in  DW  MEM ALU result.
- mem_rdata  in  DW  data-memory read data.
- mem_rdata_vld  in  1  mem_rdata valid this cycle.
- wb_regwrite  in  1  WB write enable.
- wb_waddr  in  AW  WB destination.
- wb_wdata  in  DW  WB write data.
- id_fwd_data  out  NUM_RD*DW  forwarded operands.
- hold_front  out  1  hold PC and IF/ID.
- bubble_ex  out  1  load NOP into ID/EX.
- hold_back  out  1  hold ID/EX, EX/MEM; bubble MEM/WB.
- flush_ifid  out  1  squash IF/ID.
- branch_ok  out  1  branch may redirect PC.
- haz_state  out  2  FSM state.

Behaviour:
- Forwarding (combinational, per port i):
  - If id_rd_en[i]==0 or addr==0, output id_rf_data[i].
  - Otherwise priority: EX match with ex_regwrite & !ex_isload gives ex_result.
  - Then MEM match gives mem_memtoreg ? mem_rdata : mem_aluresult.
  - Then WB match gives wb_wdata.
  - Else id_rf_data.
- Hazard detect: lu = ex_regwrite & ex_isload & ex_waddr!=0 & (any enabled port matches ex_waddr).
- mw = mem_memtoreg & mem_regwrite & !mem_rdata_vld.
- States, encoded in haz_state: RUN=0, LU=1, MW=2.
- RUN:
  - mw takes priority: hold_front=hold_back=1 combinationally, next MW.
  - else lu: hold_front=bubble_ex=1 this cycle. If LOAD_BUBBLES>1, load cnt=LOAD_BUBBLES-1 and go to LU.
- LU:
  - hold_front=bubble_ex=1.
  - cnt decrements; at cnt==1 return to RUN.
  - mw arriving in LU pre-empts to MW; cnt is kept and LU resumes after MW.
- MW:
  - hold_front=hold_back=1, bubble_ex=0.
  - On mem_rdata_vld, the hold is released that same cycle. Next state is LU if cnt!=0, else RUN.
- Branch and flush:
  - branch_ok = id_branch_taken & !hold_front.
  - flush_ifid = branch_ok.
  - A branch waiting on a load operand is re-evaluated after the stall. No PC redirect happens on stale operands.
- Reset: state RUN, cnt 0. All control outputs are 0 during and after reset until a hazard occurs. id_fwd_data passes id_rf_data.
- Reset mid-stall aborts immediately; the pipeline registers are reset by the same rst.
- Simultaneous lu+mw: mw wins, and lu is re-detected once released.

Optional Feature:
- Macro HAZ_PERF_CNT_EN adds three outputs:
  - perf_lu_cycles: 32-bit count of cycles with bubble_ex.
  - perf_mw_cycles: 32-bit count of cycles in MW.
  - perf_flushes: 32-bit count of flush_ifid pulses.
- All three saturate at 0xFFFFFFFF and reset to 0.
- Without the macro the ports are absent and no counters are built.

Decomposition:
- Shared package haz_pkg holds:
  - state enum (RUN, LU, MW);
  - forwarding-source enum (RF, EX, MEM, WB);
  - LOAD_BUBBLES maximum constant.
- Natural sub-module: haz_fwd_mux, a single-port priority forwarding mux instantiated NUM_RD times by generate.

Test Plan:
- add r3 in EX (result 0x11), ID reads r3 on port 0 → id_fwd_data[0]=0x11; no stall.
- EX r3=0x11 and MEM r3=0x22 together → EX wins: 0x11. Address 0 with EX r0 write → id_rf_data passed.
- lw r4 in EX, ID reads r4, LOAD_BUBBLES=1 → one cycle hold_front=bubble_ex=1. Next cycle forward mem_rdata=0xCAFE.
- LOAD_BUBBLES=3 load-use → bubble_ex high exactly 3 cycles; haz_state RUN→LU→LU→RUN.
- mem_memtoreg with mem_rdata_vld low for 4 cycles → hold_front/hold_back high 4 cycles, dropping in the cycle vld=1.
- id_branch_taken during load-use stall → branch_ok=0, flush_ifid=0. After release, taken branch gives branch_ok=flush_ifid=1 for one cycle.
- Assert rst in LU → all outputs 0 and state RUN asynchronously.
